// File: rtl/pet_mood_pkg.sv
// pet_mood_pkg
// Shared definitions for the pet mood block: the mood encoding seen by the
// display and sound stages, the stat width and the energy level below which
// the pet refuses to go to sleep.
package pet_mood_pkg;

  localparam int STAT_W = 4;
  localparam logic [STAT_W-1:0] STAT_MAX    = 4'd15;
  localparam logic [STAT_W-1:0] ENERGY_GATE = 4'd4;

  typedef enum logic [2:0] {
    MOOD_OK    = 3'd0,
    MOOD_NEEDY = 3'd1,
    MOOD_SLEEP = 3'd2,
    MOOD_SICK  = 3'd3,
    MOOD_DEAD  = 3'd4
  } mood_e;

endpackage

// File: rtl/pet_mood_tick_div.sv
// tick_div
// Free-running divider producing a one-cycle evaluation tick every TICK_DIV
// clock cycles. The count runs 0..TICK_DIV-1 and tick is high in the cycle
// where the count sits at TICK_DIV-1, so the first tick after reset release
// lands in cycle TICK_DIV-1.
// Ports:
//   clk     in  system clock
//   reset_n in  synchronous active-low reset
//   tick    out one-cycle evaluation strobe
module tick_div #(
  parameter int TICK_DIV = 10000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pet_mood.sv
// pet_mood
// Mood state machine fed by the six pet statistics (higher = worse). Stats
// are evaluated once per divided tick; mood, flags and alert are registered
// and therefore change the cycle after the tick.
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   hunger..social (4 bits each)  stat inputs
//   sleep_req                     one-cycle request to go to sleep
//   mood                          0 OK, 1 NEEDY, 2 SLEEP, 3 SICK, 4 DEAD
//   alert                         one-cycle pulse on entry to NEEDY/SICK/DEAD
//   sleeping, dead                decoded mood flags
//   age                           ticks survived, only with PET_MOOD_AGE_EN
// Build option: define PET_MOOD_AGE_EN to add the age port and counter.
module pet_mood
  import pet_mood_pkg::*;
#(
  parameter int TICK_DIV    = 10000,
  parameter int NEED_HI     = 12,
  parameter int NEED_LO     = 8,
  parameter int SICK_TH     = 13,
  parameter int SICK_TICKS  = 4,
  parameter int DEATH_TICKS = 8,
  parameter int SLEEP_TICKS = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [STAT_W-1:0] hunger,
  input  logic [STAT_W-1:0] happiness,
  input  logic [STAT_W-1:0] health,
  input  logic [STAT_W-1:0] hygiene,
  input  logic [STAT_W-1:0] energy,
  input  logic [STAT_W-1:0] social,
  input  logic              sleep_req,
  output logic [2:0]        mood,
  output logic              alert,
  output logic              sleeping,
  output logic              dead
`ifdef PET_MOOD_AGE_EN
  ,
  output logic [15:0]       age
`endif
);

  localparam logic [2:0] S_OK    = MOOD_OK;
  localparam logic [2:0] S_NEEDY = MOOD_NEEDY;
  localparam logic [2:0] S_SLEEP = MOOD_SLEEP;
  localparam logic [2:0] S_SICK  = MOOD_SICK;
  localparam logic [2:0] S_DEAD  = MOOD_DEAD;

  localparam int SICK_W  = $clog2(SICK_TICKS + 1);
  localparam int DEATH_W = $clog2(DEATH_TICKS + 1);
  localparam int SLEEP_W = $clog2(SLEEP_TICKS + 1);
  localparam logic [SICK_W-1:0]  SICK_MAX  = SICK_W'(SICK_TICKS);
  localparam logic [DEATH_W-1:0] DEATH_MAX = DEATH_W'(DEATH_TICKS);
  localparam logic [SLEEP_W-1:0] SLEEP_MAX = SLEEP_W'(SLEEP_TICKS);

  localparam logic [STAT_W-1:0] NEED_HI_V = STAT_W'(NEED_HI);
  localparam logic [STAT_W-1:0] NEED_LO_V = STAT_W'(NEED_LO);
  localparam logic [STAT_W-1:0] SICK_TH_V = STAT_W'(SICK_TH);

  logic               tick;
  logic [2:0]         state_q, state_d;
  logic [SICK_W-1:0]  sick_cnt_q, sick_cnt_d;
  logic [DEATH_W-1:0] death_cnt_q, death_cnt_d;
  logic [SLEEP_W-1:0] sleep_tmr_q, sleep_tmr_d;
  logic               sleep_pend_q, sleep_pend_d;
  logic               alert_q, alert_d;
  logic               need_hi_any, need_lo_all, sleep_ok, pend_eff;

  tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Next-state logic. Counters and transitions only move on tick, except
  // that sleep requests are latched in any cycle and the death counter is
  // held at zero whenever the pet is not sick.
  always_comb begin
    need_hi_any = (hunger >= NEED_HI_V) || (happiness >= NEED_HI_V) ||
                  (hygiene >= NEED_HI_V) || (social >= NEED_HI_V);
    need_lo_all = (hunger <= NEED_LO_V) && (happiness <= NEED_LO_V) &&
                  (hygiene <= NEED_LO_V) && (social <= NEED_LO_V);
    sleep_ok    = sleep_req && (energy >= ENERGY_GATE) &&
                  ((state_q == S_OK) || (state_q == S_NEEDY));
    pend_eff    = sleep_pend_q || sleep_ok;

    state_d      = state_q;
    sick_cnt_d   = sick_cnt_q;
    death_cnt_d  = death_cnt_q;
    sleep_tmr_d  = sleep_tmr_q;
    sleep_pend_d = pend_eff;
    alert_d      = 1'b0;

    if (tick) begin
      if (health >= SICK_TH_V)
        sick_cnt_d = (sick_cnt_q == SICK_MAX) ? sick_cnt_q : sick_cnt_q + SICK_W'(1);
      else
        sick_cnt_d = '0;

      if ((state_q == S_SICK) && (health == STAT_MAX) && (hunger == STAT_MAX))
        death_cnt_d = (death_cnt_q == DEATH_MAX) ? death_cnt_q : death_cnt_q + DEATH_W'(1);
      else
        death_cnt_d = '0;

      case (state_q)
        S_SICK: begin
          if (death_cnt_d == DEATH_MAX)   state_d = S_DEAD;
          else if (health < SICK_TH_V)    state_d = need_lo_all ? S_OK : S_NEEDY;
        end
        S_SLEEP: begin
          // Timer is loaded on entry; the pet wakes on the tick that drains it.
          if (sick_cnt_d == SICK_MAX) begin
            state_d = S_SICK;
          end else if (sleep_tmr_q <= SLEEP_W'(1)) begin
            state_d = need_hi_any ? S_NEEDY : S_OK;
          end else begin
            sleep_tmr_d = sleep_tmr_q - SLEEP_W'(1);
          end
        end
        S_OK, S_NEEDY: begin
          if (sick_cnt_d == SICK_MAX) begin
            state_d = S_SICK;
          end else if (pend_eff) begin
            state_d      = S_SLEEP;
            sleep_tmr_d  = SLEEP_MAX;
            sleep_pend_d = 1'b0;
          end else if ((state_q == S_OK) && need_hi_any) begin
            state_d = S_NEEDY;
          end else if ((state_q == S_NEEDY) && need_lo_all) begin
            state_d = S_OK;
          end
        end
        default: state_d = state_q;
      endcase

      alert_d = (state_d != state_q) &&
                ((state_d == S_NEEDY) || (state_d == S_SICK) || (state_d == S_DEAD));
    end

    if (state_q != S_SICK)                         death_cnt_d  = '0;
    if (state_d != S_SLEEP)                        sleep_tmr_d  = '0;
    if ((state_d == S_SICK) || (state_d == S_DEAD)) sleep_pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_OK;
      sick_cnt_q   <= '0;
      death_cnt_q  <= '0;
      sleep_tmr_q  <= '0;
      sleep_pend_q <= 1'b0;
      alert_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sick_cnt_q   <= sick_cnt_d;
      death_cnt_q  <= death_cnt_d;
      sleep_tmr_q  <= sleep_tmr_d;
      sleep_pend_q <= sleep_pend_d;
      alert_q      <= alert_d;
    end
  end

  assign mood     = state_q;
  assign alert    = alert_q;
  assign sleeping = (state_q == S_SLEEP);
  assign dead     = (state_q == S_DEAD);

`ifdef PET_MOOD_AGE_EN
  logic [15:0] age_q, age_d;

  // Age stops once the pet has died and sticks at the top value.
  always_comb begin
    age_d = age_q;
    if (tick && (state_q != S_DEAD) && (age_q != 16'hFFFF))
      age_d = age_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) age_q <= '0;
    else          age_q <= age_d;
  end

  assign age = age_q;
`endif

endmodule

// File: tb/tb_pet_mood.sv
// tb_pet_mood
// Bench for pet_mood with TICK_DIV=4. Expected observations
// {mood, alert, sleeping, dead} are queued as stimulus is applied and
// popped when the DUT output is sampled, #1 after the relevant clock edge.
module tb_pet_mood;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] hunger = '0, happiness = '0, health = '0;
  logic [3:0] hygiene = '0, energy = '0, social = '0;
  logic       sleep_req = 1'b0;
  logic [2:0] mood;
  logic       alert, sleeping, dead;
`ifdef PET_MOOD_AGE_EN
  logic [15:0] age;
`endif

  int checks = 0;
  int failures = 0;
  int tb_cnt = 0;
  logic [5:0] exp_q[$];
  logic [5:0] got, want;

  pet_mood #(.TICK_DIV(TICK_DIV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .hunger    (hunger),
    .happiness (happiness),
    .health    (health),
    .hygiene   (hygiene),
    .energy    (energy),
    .social    (social),
    .sleep_req (sleep_req),
    .mood      (mood),
    .alert     (alert),
    .sleeping  (sleeping),
    .dead      (dead)
`ifdef PET_MOOD_AGE_EN
    ,
    .age       (age)
`endif
  );

  always #5 clk = ~clk;

  // Independent model of the tick position: tick is the cycle with tb_cnt==3.
  always @(posedge clk) begin
    if (!reset_n) tb_cnt <= 0;
    else          tb_cnt <= (tb_cnt == TICK_DIV - 1) ? 0 : tb_cnt + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [5:0] ex(input logic [2:0] m, input logic a);
    return {m, a, (m == 3'd2), (m == 3'd4)};
  endfunction

  task automatic set_stats(input logic [3:0] hu, ha, he, hy, en, so);
    hunger = hu; happiness = ha; health = he; hygiene = hy; energy = en; social = so;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    sleep_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Advance to just after the next tick edge; optionally raise sleep_req
  // during the tick cycle itself.
  task automatic next_tick(input logic req);
    int n = 0;
    @(negedge clk);
    while (tb_cnt != TICK_DIV - 1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) begin
      failures++;
      $display("[TB] FAIL tick_wait got=timeout want=tick");
    end
    sleep_req = req;
    @(posedge clk);
    #1;
    sleep_req = 1'b0;
  endtask

  task automatic pulse_sleep();
    @(negedge clk);
    sleep_req = 1'b1;
    @(negedge clk);
    sleep_req = 1'b0;
  endtask

  task automatic test_reset();
    set_stats(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(ex(3'd0, 1'b0));
    got = {mood, alert, sleeping, dead};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL reset_state got=%b want=%b", got, want);
    end
`ifdef PET_MOOD_AGE_EN
    checks++;
    if (age !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_age got=%0d want=0", age);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(ex(3'd0, 1'b0));
    next_tick(1'b0);
    got = {mood, alert, sleeping, dead};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL first_tick_idle got=%b want=%b", got, want);
    end
  endtask

  task automatic test_needy();
    logic [3:0] hu_t [6] = '{4'd10, 4'd8, 4'd11, 4'd0, 4'd0, 4'd0};
    logic [3:0] so_t [6] = '{4'd0, 4'd0, 4'd0, 4'd12, 4'd9, 4'd8};
    logic [3:0] hy_t [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd8};
    logic [2:0] m_t  [6] = '{3'd1, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0};
    logic       a_t  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    set_stats(4'd12, 0, 0, 0, 0, 0);
    // Mood must stay OK until the edge closing cycle TICK_DIV-1.
    for (int c = 0; c < TICK_DIV; c++) begin
      exp_q.push_back(ex((c == TICK_DIV - 1) ? 3'd1 : 3'd0, c == TICK_DIV - 1));
      @(posedge clk);
      #1;
      got = {mood, alert, sleeping, dead};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL tick_timing cycle=%0d got=%b want=%b", c, got, want);
      end
    end
    exp_q.push_back(ex(3'd1, 1'b0));
    @(posedge clk);
    #1;
    got = {mood, alert, sleeping, dead};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL needy_alert_once got=%b want=%b", got, want);
    end
    for (int i = 0; i < 6; i++) begin
      set_stats(hu_t[i], 0, 0, hy_t[i], 0, so_t[i]);
      exp_q.push_back(ex(m_t[i], a_t[i]));
      next_tick(1'b0);
      got = {mood, alert, sleeping, dead};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL needy_step%0d got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_sick();
    do_reset();
    set_stats(0, 0, 4'd13, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ex((i == 3) ? 3'd3 : 3'd0, i == 3));
      next_tick(1'b0);
      got = {mood, alert, sleeping, dead};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL sick_enter tick=%0d got=%b want=%b", i, got, want);
      end
    end
    set_stats(0, 0, 4'd12, 0, 0, 0);
    exp_q.push_back(ex(3'd0, 1'b0));
    next_tick(1'b0);
    got = {mood, alert, sleeping, dead};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL sick_exit_ok got=%b want=%b", got, want);
    end
    // Back into SICK with hunger just above NEED_LO, then recover to NEEDY.
    set_stats(4'd9, 0, 4'd13, 0, 0, 0);
    repeat (4) next_tick(1'b0);
    exp_q.push_back(ex(3'd1, 1'b1));
    set_stats(4'd9, 0, 4'd12, 0, 0, 0);
    next_tick(1'b0);
    got = {mood, alert, sleeping, dead};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL sick_exit_needy got=%b want=%b", got, want);
    end
  endtask

  task automatic test_death();
    do_reset();
    set_stats(0, 0, 4'd13, 0, 0, 0);
    repeat (4) next_tick(1'b0);
    // Five qualifying ticks, an interruption, then a full run of eight.
    for (int i = 0; i < 14; i++) begin
      if (i == 5) set_stats(4'd14, 0, 4'd15, 0, 0, 0);
      else        set_stats(4'd15, 0, 4'd15, 0, 0, 0);
      exp_q.push_back(ex((i == 13) ? 3'd4 : 3'd3, i == 13));
      next_tick(1'b0);
      got = {mood, alert, sleeping, dead};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL death_run tick=%0d got=%b want=%b", i, got, want);
      end
    end
    set_stats(0, 0, 0, 0, 4'd5, 0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(ex(3'd4, 1'b0));
      next_tick(i == 1);
      got = {mood, alert, sleeping, dead};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL dead_absorbing tick=%0d got=%b want=%b", i, got, want);
      end
    end
    @(negedge clk);
    reset_n = 1'b0;
    exp_q.push_back(ex(3'd0, 1'b0));
    @(posedge clk);
    #1;
    got = {mood, alert, sleeping, dead};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL reset_from_dead got=%b want=%b", got, want);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_sleep();
    do_reset();
    set_stats(0, 0, 0, 0, 4'd5, 0);
    pulse_sleep();
    exp_q.push_back(ex(3'd2, 1'b0));
    next_tick(1'b0);
    got = {mood, alert, sleeping, dead};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL sleep_enter got=%b want=%b", got, want);
    end
    // Hunger goes high while asleep: no NEEDY until the pet wakes.
    set_stats(4'd12, 0, 0, 0, 4'd5, 0);
    for (int i = 1; i <= 6; i++) begin
      exp_q.push_back(ex((i == 6) ? 3'd1 : 3'd2, i == 6));
      next_tick(1'b0);
      got = {mood, alert, sleeping, dead};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL sleep_timer tick=%0d got=%b want=%b", i, got, want);
      end
    end
    set_stats(0, 0, 0, 0, 4'd3, 0);
    exp_q.push_back(ex(3'd0, 1'b0));
    next_tick(1'b0);
    exp_q.push_back(ex(3'd0, 1'b0));
    pulse_sleep();
    next_tick(1'b0);
    want = exp_q.pop_front();
    got = {mood, alert, sleeping, dead};
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL sleep_wake_ok got=%b want=%b", got, want);
    end
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL sleep_low_energy got=%b want=%b", got, want);
    end
    set_stats(0, 0, 0, 0, 4'd4, 0);
    exp_q.push_back(ex(3'd2, 1'b0));
    next_tick(1'b1);
    got = {mood, alert, sleeping, dead};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL sleep_coincident got=%b want=%b", got, want);
    end
  endtask

`ifdef PET_MOOD_AGE_EN
  task automatic test_age();
    do_reset();
    set_stats(0, 0, 0, 0, 0, 0);
    repeat (10) next_tick(1'b0);
    checks++;
    if (age !== 16'd10) begin
      failures++;
      $display("[TB] FAIL age_count got=%0d want=10", age);
    end
    set_stats(0, 0, 4'd13, 0, 0, 0);
    repeat (4) next_tick(1'b0);
    set_stats(4'd15, 0, 4'd15, 0, 0, 0);
    repeat (8) next_tick(1'b0);
    checks++;
    if (age !== 16'd22) begin
      failures++;
      $display("[TB] FAIL age_at_death got=%0d want=22", age);
    end
    repeat (2) next_tick(1'b0);
    checks++;
    if (age !== 16'd22) begin
      failures++;
      $display("[TB] FAIL age_frozen got=%0d want=22", age);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_needy();
    test_sick();
    test_death();
    test_sleep();
`ifdef PET_MOOD_AGE_EN
    test_age();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
